hwpe_ctrl_uloop_buffer: RTL and testbench
=========================================

HWPE_CTRL_ULOOP_BUFFER -- requirements
Module: hwpe_ctrl_uloop_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-002 SHALL have parameter NB_REG, default ULOOP_MAX_NB_REG: number of 32-bit offsets carried per entry.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-006 SHALL have port en_i, input, 1 bit: start/enable from the controller FSM.
REQ-007 SHALL have port flags_uloop_i, input, flags_uloop_t: uloop output (valid, done, offs, idx, loop).
REQ-008 SHALL have port ctrl_uloop_o, output, ctrl_uloop_t: enable/ready/clear driven back to the uloop.
REQ-009 SHALL have port out_valid_o, output, 1 bit: head entry valid.
REQ-010 SHALL have port out_ready_i, input, 1 bit: consumer accepts the head entry.
REQ-011 SHALL have port out_offs_o, output, NB_REG x 32 bits: head offsets.
REQ-012 SHALL have port out_idx_o, output, ULOOP_MAX_NB_LOOPS x ULOOP_MAX_CNT_WIDTH bits: head indices.
REQ-013 SHALL have port out_loop_o, output, $clog2(ULOOP_MAX_NB_LOOPS) bits: head loop level.
REQ-014 SHALL have port out_last_o, output, 1 bit: head entry was captured together with uloop done.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH+1) bits: occupancy.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle pulse when the last entry is consumed.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE SHALL hold ctrl_uloop_o.enable=0 and ready=0; en_i=1 moves it to RUN.
REQ-019 RUN SHALL drive enable=1 and ready=~full.
REQ-020 A push SHALL occur when flags_uloop_i.valid & ctrl_uloop_o.ready.
REQ-021 A push with flags_uloop_i.done=1 SHALL store last=1 and move RUN to DRAIN.
REQ-022 DRAIN SHALL drive enable=0 and ready=0, and SHALL move to DONE when the last=1 entry pops.
REQ-023 DONE SHALL assert done_o=1 for exactly one cycle, then return to IDLE.
REQ-024 A pop SHALL occur when out_valid_o & out_ready_i; out_valid_o=~empty.
REQ-025 Outputs SHALL be driven from registered storage; latency from push to out_valid_o is 1 cycle, with no combinational bypass.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; with full=1 no push is possible, so a pop alone occurs.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from count, with full=(count==DEPTH).
REQ-028 Output fields SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-029 clear_i SHALL, in any state, empty the buffer, return the FSM to IDLE and suppress done_o; ctrl_uloop_o.clear SHALL equal clear_i combinationally.
REQ-030 clear_i SHALL take priority over a simultaneous push, pop or en_i.
REQ-031 en_i SHALL be ignored outside IDLE.

Reset
REQ-032 rst_i=1 SHALL set the FSM to IDLE, pointers and count to 0, and done_o=0.
REQ-033 During reset, out_valid_o=0, out_last_o=0, and ctrl_uloop_o.enable/ready=0.
REQ-034 Storage contents need not be reset; outputs are qualified by out_valid_o.
REQ-035 Reset asserted mid-operation SHALL behave as REQ-032, with no done_o pulse.

Structure
REQ-036 The entry typedef uloop_buf_entry_t (offs, idx, loop, last) and ULOOP_BUF_DEPTH=4 SHALL reside in hwpe_ctrl_package.
REQ-037 Storage and pointer logic SHALL be a sub-module hwpe_ctrl_uloop_buf_fifo; the FSM lives in the top module.

Verification
REQ-038 Scenario: en_i=1, uloop emits 3 valids at offs[0]=0x10,0x20,0x30 with out_ready_i=1 -> outputs appear in order, each 1 cycle after push, count_o<=1.
REQ-039 Scenario: out_ready_i=0, 6 valids offered, DEPTH=4 -> 4 accepted, ctrl ready=0 at count_o=4, held data stable; raising out_ready_i drains in order.
REQ-040 Scenario: 5th valid carries done=1 -> entry stored with last=1, FSM enters DRAIN and ready=0; done_o pulses once when that entry pops, then IDLE.
REQ-041 Scenario: full buffer with out_ready_i=1 and valid=1 in the same cycle -> pop only, count 4->3, push next cycle.
REQ-042 Scenario: clear_i during DRAIN with count_o=2 -> next cycle count_o=0, out_valid_o=0, IDLE, no done_o, ctrl_uloop_o.clear=1 in the clear cycle.
REQ-043 Scenario: rst_i pulse mid-RUN with count_o=3 -> all outputs at reset values next cycle; en_i restarts cleanly.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// rtl/hwpe_ctrl_package.sv - shared uloop types, buffer entry and FSM state encoding
package hwpe_ctrl_package;

    localparam int unsigned ULOOP_MAX_NB_REG    = 4;
    localparam int unsigned ULOOP_MAX_NB_LOOPS  = 6;
    localparam int unsigned ULOOP_MAX_CNT_WIDTH = 16;
    localparam int unsigned ULOOP_LOOP_W        = $clog2(ULOOP_MAX_NB_LOOPS);
    localparam int unsigned ULOOP_BUF_DEPTH     = 4;

    typedef struct packed {
        logic                                                   valid;
        logic                                                   done;
        logic [ULOOP_MAX_NB_REG-1:0][31:0]                      offs;
        logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_MAX_CNT_WIDTH-1:0] idx;
        logic [ULOOP_LOOP_W-1:0]                                loop;
    } flags_uloop_t;

    typedef struct packed {
        logic enable;
        logic ready;
        logic clear;
    } ctrl_uloop_t;

    typedef struct packed {
        logic [ULOOP_MAX_NB_REG-1:0][31:0]                      offs;
        logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_MAX_CNT_WIDTH-1:0] idx;
        logic [ULOOP_LOOP_W-1:0]                                loop;
        logic                                                   last;
    } uloop_buf_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } uloop_buf_state_e;

    // The done flag of the uloop becomes the entry's last marker.
    function automatic uloop_buf_entry_t uloop_buf_capture(input flags_uloop_t flags);
        uloop_buf_entry_t entry;
        entry.offs = flags.offs;
        entry.idx  = flags.idx;
        entry.loop = flags.loop;
        entry.last = flags.done;
        return entry;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_uloop_buffer_if.sv
// rtl/hwpe_ctrl_uloop_buffer_if.sv - valid/ready stream of uloop buffer entries
interface hwpe_ctrl_uloop_buffer_if;
    import hwpe_ctrl_package::*;

    logic             valid;
    logic             ready;
    uloop_buf_entry_t data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/hwpe_ctrl_uloop_buf_fifo.sv
// rtl/hwpe_ctrl_uloop_buf_fifo.sv - registered entry storage with wrapping pointers and occupancy count
module hwpe_ctrl_uloop_buf_fifo
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned DEPTH = ULOOP_BUF_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    hwpe_ctrl_uloop_buffer_if.slave        push_s,
    hwpe_ctrl_uloop_buffer_if.master       pop_m,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    uloop_buf_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push;
    logic               pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign push_s.ready = ~full_o;
    assign pop_m.valid  = ~empty_o;
    assign pop_m.data   = mem_q[rptr_q];

    // Clear wins over any transfer in the same cycle.
    assign push = push_s.valid & ~full_o & ~clear_i;
    assign pop  = pop_m.valid & pop_m.ready & ~clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= push_s.data;
        end
    end

endmodule

// File: rtl/hwpe_ctrl_uloop_buffer.sv
// rtl/hwpe_ctrl_uloop_buffer.sv - decouples uloop iteration output from its consumer; run/drain/done control
module hwpe_ctrl_uloop_buffer
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned DEPTH  = ULOOP_BUF_DEPTH,
    parameter int unsigned NB_REG = ULOOP_MAX_NB_REG
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_i,
    input  logic                                                    clear_i,
    input  logic                                                    en_i,
    input  flags_uloop_t                                            flags_uloop_i,
    output ctrl_uloop_t                                             ctrl_uloop_o,
    output logic                                                    out_valid_o,
    input  logic                                                    out_ready_i,
    output logic [NB_REG-1:0][31:0]                                 out_offs_o,
    output logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_MAX_CNT_WIDTH-1:0]  out_idx_o,
    output logic [$clog2(ULOOP_MAX_NB_LOOPS)-1:0]                   out_loop_o,
    output logic                                                    out_last_o,
    output logic [$clog2(DEPTH+1)-1:0]                              count_o,
    output logic                                                    done_o
);

    uloop_buf_state_e state_q, state_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             run_enable;
    logic             run_ready;
    logic             done_pulse;
    logic             last_pop;

    hwpe_ctrl_uloop_buffer_if push_if ();
    hwpe_ctrl_uloop_buffer_if pop_if ();

    // Only RUN offers ready to the uloop, so pushes are confined to RUN.
    assign push_if.valid = flags_uloop_i.valid & (state_q == RUN);
    assign push_if.data  = uloop_buf_capture(flags_uloop_i);
    assign pop_if.ready  = out_ready_i;

    hwpe_ctrl_uloop_buf_fifo #(
        .DEPTH (DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_s  (push_if),
        .pop_m   (pop_if),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign last_pop = pop_if.valid & out_ready_i & pop_if.data.last;

    always_comb begin
        state_d    = state_q;
        run_enable = 1'b0;
        run_ready  = 1'b0;
        done_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                run_enable = 1'b1;
                run_ready  = ~fifo_full;
                if (flags_uloop_i.valid & ~fifo_full & flags_uloop_i.done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset forces handshakes low even in the cycle it is first seen.
    always_comb begin
        ctrl_uloop_o        = '0;
        ctrl_uloop_o.enable = run_enable & ~rst_i;
        ctrl_uloop_o.ready  = run_ready & ~rst_i;
        ctrl_uloop_o.clear  = clear_i;
    end

    assign done_o      = done_pulse & ~clear_i & ~rst_i;
    assign out_valid_o = ~fifo_empty & ~rst_i;
    assign out_last_o  = out_valid_o & pop_if.data.last;
    assign out_offs_o  = pop_if.data.offs[NB_REG-1:0];
    assign out_idx_o   = pop_if.data.idx;
    assign out_loop_o  = pop_if.data.loop;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_buffer.sv
// tb/tb_hwpe_ctrl_uloop_buffer.sv - cycle-table and scoreboard bench for hwpe_ctrl_uloop_buffer
module tb_hwpe_ctrl_uloop_buffer;
    import hwpe_ctrl_package::*;

    localparam int DEPTH  = 4;
    localparam int NB_REG = ULOOP_MAX_NB_REG;

    logic                                                   clk = 1'b0;
    logic                                                   rst_i;
    logic                                                   clear_i;
    logic                                                   en_i;
    flags_uloop_t                                           flags;
    ctrl_uloop_t                                            ctrl;
    logic [NB_REG-1:0][31:0]                                out_offs;
    logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_MAX_CNT_WIDTH-1:0] out_idx;
    logic [ULOOP_LOOP_W-1:0]                                out_loop;
    logic                                                   out_last;
    logic [2:0]                                             count;
    logic                                                   done;

    int tests = 0;
    int fails = 0;

    hwpe_ctrl_uloop_buffer_if out_if ();

    always #5 clk = ~clk;

    hwpe_ctrl_uloop_buffer #(
        .DEPTH  (DEPTH),
        .NB_REG (NB_REG)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .en_i          (en_i),
        .flags_uloop_i (flags),
        .ctrl_uloop_o  (ctrl),
        .out_valid_o   (out_if.valid),
        .out_ready_i   (out_if.ready),
        .out_offs_o    (out_offs),
        .out_idx_o     (out_idx),
        .out_loop_o    (out_loop),
        .out_last_o    (out_last),
        .count_o       (count),
        .done_o        (done)
    );

    assign out_if.data.offs = out_offs;
    assign out_if.data.idx  = out_idx;
    assign out_if.data.loop = out_loop;
    assign out_if.data.last = out_last;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic r, input logic c,
                         input logic e, input logic [31:0] offs);
        flags         = '0;
        flags.valid   = v;
        flags.done    = d;
        flags.offs[0] = offs;
        flags.offs[1] = ~offs;
        flags.idx[0]  = offs[15:0] ^ 16'h5a5a;
        flags.idx[2]  = offs[15:0];
        flags.loop    = offs[2:0];
        out_if.ready  = r;
        clear_i       = c;
        en_i          = e;
    endtask

    // Scoreboard: entries expected in acceptance order, compared on each pop.
    typedef struct {
        uloop_buf_entry_t ent;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        if (rst_i || clear_i) begin
            sb_q.delete();
        end else begin
            if (out_if.valid && out_if.ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_pop_when_empty", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_offs", out_if.data.offs, sb_e.ent.offs);
                    check("sb_idx",  out_if.data.idx,  sb_e.ent.idx);
                    check("sb_loop", out_if.data.loop, sb_e.ent.loop);
                    check("sb_last", out_if.data.last, sb_e.ent.last);
                end
            end
            if (flags.valid && ctrl.ready) begin
                sb_e.ent.offs = flags.offs;
                sb_e.ent.idx  = flags.idx;
                sb_e.ent.loop = flags.loop;
                sb_e.ent.last = flags.done;
                sb_q.push_back(sb_e);
            end
        end
    end

    typedef struct {
        logic        v, d, r, c, e;
        logic [31:0] offs;
        logic        x_en, x_rdy, x_vo;
        int          x_cnt;
        logic        x_done;
        logic [31:0] x_head;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic v, d, r, c, e, input logic [31:0] offs,
                       input logic x_en, x_rdy, x_vo, input int x_cnt,
                       input logic x_done, input logic [31:0] x_head);
        vec_t t;
        t = '{v, d, r, c, e, offs, x_en, x_rdy, x_vo, x_cnt, x_done, x_head};
        tbl.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rows: inputs {v,d,r,c,e,offs}, expected {enable,ready,valid,count,done,head}
        add(0,0,0,0,1,32'h00, 0,0,0,0,0,32'h00);
        add(1,0,1,0,0,32'h10, 1,1,0,0,0,32'h00);
        add(1,0,1,0,0,32'h20, 1,1,1,1,0,32'h10);
        add(1,0,1,0,0,32'h30, 1,1,1,1,0,32'h20);
        add(0,0,1,0,0,32'h00, 1,1,1,1,0,32'h30);
        add(0,0,0,0,0,32'h00, 1,1,0,0,0,32'h00);
        add(1,0,0,0,0,32'h41, 1,1,0,0,0,32'h00);
        add(1,0,0,0,0,32'h42, 1,1,1,1,0,32'h41);
        add(1,0,0,0,0,32'h43, 1,1,1,2,0,32'h41);
        add(1,0,0,0,0,32'h44, 1,1,1,3,0,32'h41);
        add(1,0,0,0,0,32'h45, 1,0,1,4,0,32'h41);
        add(1,0,0,0,0,32'h46, 1,0,1,4,0,32'h41);
        add(1,0,1,0,0,32'h45, 1,0,1,4,0,32'h41);
        add(1,0,0,0,0,32'h45, 1,1,1,3,0,32'h42);
        add(0,0,1,0,0,32'h00, 1,0,1,4,0,32'h42);
        add(0,0,1,0,0,32'h00, 1,1,1,3,0,32'h43);
        add(0,0,1,0,0,32'h00, 1,1,1,2,0,32'h44);
        add(0,0,1,0,0,32'h00, 1,1,1,1,0,32'h45);
        add(0,0,0,0,0,32'h00, 1,1,0,0,0,32'h00);
        add(1,0,0,0,0,32'h51, 1,1,0,0,0,32'h00);
        add(1,0,0,0,0,32'h52, 1,1,1,1,0,32'h51);
        add(1,0,1,0,0,32'h53, 1,1,1,2,0,32'h51);
        add(1,0,0,0,0,32'h54, 1,1,1,2,0,32'h52);
        add(1,1,0,0,0,32'h55, 1,1,1,3,0,32'h52);
        add(0,0,0,0,1,32'h00, 0,0,1,4,0,32'h52);
        add(0,0,1,0,0,32'h00, 0,0,1,4,0,32'h52);
        add(0,0,1,0,0,32'h00, 0,0,1,3,0,32'h53);
        add(0,0,1,0,0,32'h00, 0,0,1,2,0,32'h54);
        add(0,0,1,0,0,32'h00, 0,0,1,1,0,32'h55);
        add(0,0,0,0,0,32'h00, 0,0,0,0,1,32'h00);
        add(0,0,0,0,0,32'h00, 0,0,0,0,0,32'h00);
        add(0,0,0,0,1,32'h00, 0,0,0,0,0,32'h00);
        add(1,0,0,0,0,32'h61, 1,1,0,0,0,32'h00);
        add(1,1,0,0,0,32'h62, 1,1,1,1,0,32'h61);
        add(0,0,1,1,1,32'h00, 0,0,1,2,0,32'h61);
        add(0,0,0,0,0,32'h00, 0,0,0,0,0,32'h00);
        add(0,0,0,0,0,32'h00, 0,0,0,0,0,32'h00);

        rst_i = 1'b1;
        drive(0,0,0,0,0,32'h0);
        cyc();
        @(negedge clk);
        check("rst_valid",  out_if.valid, 0);
        check("rst_enable", ctrl.enable,  0);
        check("rst_ready",  ctrl.ready,   0);
        check("rst_last",   out_if.data.last, 0);
        check("rst_done",   done,         0);
        cyc();
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_count", count, 0);

        foreach (tbl[i]) begin
            cyc();
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].offs);
            @(negedge clk);
            check($sformatf("row%0d_enable", i), ctrl.enable, tbl[i].x_en);
            check($sformatf("row%0d_ready",  i), ctrl.ready,  tbl[i].x_rdy);
            check($sformatf("row%0d_clear",  i), ctrl.clear,  tbl[i].c);
            check($sformatf("row%0d_valid",  i), out_if.valid, tbl[i].x_vo);
            check($sformatf("row%0d_count",  i), count,       tbl[i].x_cnt);
            check($sformatf("row%0d_done",   i), done,        tbl[i].x_done);
            if (tbl[i].x_vo) begin
                check($sformatf("row%0d_head", i), out_if.data.offs[0], tbl[i].x_head);
            end
        end

        // Reset in the middle of a run with three entries buffered, then restart.
        cyc(); drive(0,0,0,0,1,32'h0);
        cyc(); drive(1,0,0,0,0,32'h71);
        cyc(); drive(1,0,0,0,0,32'h72);
        cyc(); drive(1,0,0,0,0,32'h73);
        cyc(); drive(0,0,0,0,0,32'h0);
        @(negedge clk);
        check("midrun_count", count, 3);
        cyc(); rst_i = 1'b1;
        @(negedge clk);
        check("midrst_valid",  out_if.valid, 0);
        check("midrst_enable", ctrl.enable,  0);
        check("midrst_ready",  ctrl.ready,   0);
        check("midrst_done",   done,         0);
        cyc(); rst_i = 1'b0;
        @(negedge clk);
        check("after_rst_count",  count,        0);
        check("after_rst_valid",  out_if.valid, 0);
        check("after_rst_enable", ctrl.enable,  0);
        check("after_rst_done",   done,         0);
        cyc(); drive(0,0,0,0,1,32'h0);
        cyc(); drive(1,0,1,0,0,32'h81);
        @(negedge clk);
        check("restart_enable", ctrl.enable, 1);
        check("restart_ready",  ctrl.ready,  1);
        cyc(); drive(0,0,1,0,0,32'h0);
        @(negedge clk);
        check("restart_valid", out_if.valid, 1);
        check("restart_head",  out_if.data.offs[0], 32'h81);
        check("restart_count", count, 1);
        cyc(); drive(0,0,0,0,0,32'h0);
        @(negedge clk);
        check("restart_drained", count, 0);
        check("sb_leftover", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
